// File: rtl/storebuffer_drain_pkg.sv
// Shared cache types for the store buffer drain engine.
// Holds the cache line width and the drain FSM state encoding.
// Also supplies fallback values for the address/word width macros when the
// surrounding build does not define them.

`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package storebuffer_drain_pkg;

  localparam int unsigned CacheLineWidth = 128;

  // Drain FSM states, kept as plain constants for older consumers.
  typedef logic [2:0] drain_state_t;
  localparam drain_state_t StIdle     = 3'd0;
  localparam drain_state_t StLookup   = 3'd1;
  localparam drain_state_t StWrite    = 3'd2;
  localparam drain_state_t StEvict    = 3'd3;
  localparam drain_state_t StFillReq  = 3'd4;
  localparam drain_state_t StFillWait = 3'd5;
  localparam drain_state_t StWthru    = 3'd6;

endpackage

// File: rtl/storebuffer_drain.sv
// Store buffer drain engine.
// Retires one store buffer entry at a time into the data cache.
// - On a hit the word is written into the cache.
// - On a miss, what happens depends on the build option below.
//
// Build option: STOREBUFFER_DRAIN_WRITE_ALLOCATE_EN
// - Defined: a miss allocates. A dirty victim is written back, the line is
//   read and installed, and then the word is written.
// - Undefined: a miss writes the word straight through to memory.
//
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   sb_*                    store buffer head entry and its pop strobe
//   cache_grant/req/addr    tag port arbitration and lookup
//   cache_hit/victim_*      lookup result, valid the cycle after cache_req
//   cache_we/wdata/wbe      word write into the cache
//   cache_fill/fill_line    line install into the cache
//   mem_*                   line-wide memory request/response channel
//   busy                    engine is not idle

`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module storebuffer_drain
  import storebuffer_drain_pkg::*;
#(
  parameter int unsigned TAG_WIDTH  = `PHYSICAL_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = `WORD_WIDTH,
  parameter int unsigned LINE_WIDTH = CacheLineWidth
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sb_empty,
  input  logic [TAG_WIDTH-1:0]    sb_tag,
  input  logic [DATA_WIDTH-1:0]   sb_data,
  input  logic [3:0]              sb_bytes,
  output logic                    sb_pop,
  input  logic                    cache_grant,
  output logic                    cache_req,
  output logic [TAG_WIDTH-1:0]    cache_addr,
  input  logic                    cache_hit,
  input  logic                    cache_victim_dirty,
  input  logic [TAG_WIDTH-1:0]    cache_victim_addr,
  input  logic [LINE_WIDTH-1:0]   cache_victim_line,
  output logic                    cache_we,
  output logic [DATA_WIDTH-1:0]   cache_wdata,
  output logic [3:0]              cache_wbe,
  output logic                    cache_fill,
  output logic [LINE_WIDTH-1:0]   cache_fill_line,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_we,
  output logic [TAG_WIDTH-1:0]    mem_addr,
  output logic [LINE_WIDTH-1:0]   mem_wdata,
  output logic [LINE_WIDTH/8-1:0] mem_wbe,
  input  logic                    mem_rvalid,
  input  logic [LINE_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int unsigned LineBytes = LINE_WIDTH / 8;
  localparam int unsigned OffBits   = $clog2(LineBytes);

  drain_state_t            state_q, state_d;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [3:0]              bytes_q;
  logic                    req_fire;
  logic [TAG_WIDTH-1:0]    line_addr;

  assign req_fire  = (state_q == StIdle) && !sb_empty && cache_grant;
  assign line_addr = {tag_q[TAG_WIDTH-1:OffBits], OffBits'(0)};

`ifdef STOREBUFFER_DRAIN_WRITE_ALLOCATE_EN
  // Victim info is only valid during the lookup cycle, so keep a copy for EVICT.
  logic [TAG_WIDTH-1:0]  victim_addr_q;
  logic [LINE_WIDTH-1:0] victim_line_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      victim_addr_q <= '0;
      victim_line_q <= '0;
    end else if (state_q == StLookup) begin
      victim_addr_q <= cache_victim_addr;
      victim_line_q <= cache_victim_line;
    end
  end
`else
  logic [OffBits-3:0] word_idx;
  logic               unused_alloc_inputs;

  assign word_idx            = tag_q[OffBits-1:2];
  assign unused_alloc_inputs = ^{cache_victim_dirty, cache_victim_addr, cache_victim_line,
                                 mem_rvalid, mem_rdata};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      tag_q   <= '0;
      data_q  <= '0;
      bytes_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        tag_q   <= sb_tag;
        data_q  <= sb_data;
        bytes_q <= sb_bytes;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_fire) state_d = StLookup;
      StLookup: begin
        if (cache_hit) begin
          state_d = StWrite;
        end else begin
`ifdef STOREBUFFER_DRAIN_WRITE_ALLOCATE_EN
          state_d = cache_victim_dirty ? StEvict : StFillReq;
`else
          state_d = StWthru;
`endif
        end
      end
      StWrite:    state_d = StIdle;
`ifdef STOREBUFFER_DRAIN_WRITE_ALLOCATE_EN
      StEvict:    if (mem_ready) state_d = StFillReq;
      StFillReq:  if (mem_ready) state_d = StFillWait;
      StFillWait: if (mem_rvalid) state_d = StWrite;
`else
      StWthru:    if (mem_ready) state_d = StIdle;
`endif
      default:    state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the registered state only (plus the handshake
  // inputs), so request fields hold steady while a memory request stalls.
  always_comb begin
    sb_pop          = 1'b0;
    cache_req       = 1'b0;
    cache_addr      = '0;
    cache_we        = 1'b0;
    cache_wdata     = '0;
    cache_wbe       = '0;
    cache_fill      = 1'b0;
    cache_fill_line = '0;
    mem_valid       = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_wbe         = '0;
    busy            = 1'b0;
    if (!reset) begin
      busy       = (state_q != StIdle);
      cache_addr = tag_q;
      case (state_q)
        StIdle: begin
          cache_req  = req_fire;
          cache_addr = req_fire ? sb_tag : '0;
        end
        StWrite: begin
          cache_we    = 1'b1;
          cache_wdata = data_q;
          cache_wbe   = bytes_q;
          sb_pop      = 1'b1;
        end
`ifdef STOREBUFFER_DRAIN_WRITE_ALLOCATE_EN
        StEvict: begin
          mem_valid = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = victim_addr_q;
          mem_wdata = victim_line_q;
          mem_wbe   = '1;
        end
        StFillReq: begin
          mem_valid = 1'b1;
          mem_addr  = line_addr;
        end
        StFillWait: begin
          if (mem_rvalid) begin
            cache_fill      = 1'b1;
            cache_fill_line = mem_rdata;
          end
        end
`else
        StWthru: begin
          mem_valid = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = line_addr;
          mem_wdata = LINE_WIDTH'(data_q) << (DATA_WIDTH * word_idx);
          mem_wbe   = LineBytes'(bytes_q) << (4 * word_idx);
          sb_pop    = mem_ready;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_storebuffer_drain.sv
module tb_storebuffer_drain;

  logic         clock = 1'b0;
  logic         reset;
  logic         sb_empty;
  logic [31:0]  sb_tag, sb_data;
  logic [3:0]   sb_bytes;
  logic         sb_pop;
  logic         cache_grant, cache_req;
  logic [31:0]  cache_addr;
  logic         cache_hit, cache_victim_dirty;
  logic [31:0]  cache_victim_addr;
  logic [127:0] cache_victim_line;
  logic         cache_we;
  logic [31:0]  cache_wdata;
  logic [3:0]   cache_wbe;
  logic         cache_fill;
  logic [127:0] cache_fill_line;
  logic         mem_valid, mem_ready, mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_wbe;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;
  logic         busy;

  always #5 clock = ~clock;

  storebuffer_drain #(.TAG_WIDTH(32), .DATA_WIDTH(32), .LINE_WIDTH(128)) dut (
    .clock(clock), .reset(reset), .sb_empty(sb_empty), .sb_tag(sb_tag), .sb_data(sb_data),
    .sb_bytes(sb_bytes), .sb_pop(sb_pop), .cache_grant(cache_grant), .cache_req(cache_req),
    .cache_addr(cache_addr), .cache_hit(cache_hit), .cache_victim_dirty(cache_victim_dirty),
    .cache_victim_addr(cache_victim_addr), .cache_victim_line(cache_victim_line),
    .cache_we(cache_we), .cache_wdata(cache_wdata), .cache_wbe(cache_wbe),
    .cache_fill(cache_fill), .cache_fill_line(cache_fill_line), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wbe(mem_wbe), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct packed {
    logic [31:0]  tag;
    logic [31:0]  data;
    logic [3:0]   bytes;
    logic         hit;
    logic         vdirty;
    logic [31:0]  vaddr;
    logic [127:0] vline;
    int           stall;
    int           gdelay;
  } entry_t;

  typedef struct packed {
    int           pop_lat;  // -1: latency not fixed
    int           cw;
    logic [31:0]  cw_data;
    logic [3:0]   cw_be;
    int           fill;
    int           mem_n;
    logic         m0_we;
    logic [31:0]  m0_addr;
    logic [127:0] m0_wdata;
    logic [15:0]  m0_wbe;
    logic         m1_we;
    logic [31:0]  m1_addr;
    logic [127:0] m1_wdata;
    logic [15:0]  m1_wbe;
  } exp_t;

  typedef struct packed {
    entry_t in;
    exp_t   ex;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations of one drained entry
  int           o_pop, o_pop_lat, o_cw, o_fill, o_mem_n, o_unstable, o_err, o_timeout, o_req;
  logic [31:0]  o_req_addr, o_cw_addr, o_cw_data;
  logic [3:0]   o_cw_be;
  logic [127:0] o_fill_line, rd_data_used;
  logic         o_m_we    [2];
  logic [31:0]  o_m_addr  [2];
  logic [127:0] o_m_wdata [2];
  logic [15:0]  o_m_wbe   [2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic entry_t mk_in(logic [31:0] tag, logic [31:0] data, logic [3:0] bytes,
                                   logic hit, logic vdirty, logic [31:0] vaddr,
                                   logic [127:0] vline, int stall, int gdelay);
    entry_t e;
    e.tag = tag; e.data = data; e.bytes = bytes; e.hit = hit; e.vdirty = vdirty;
    e.vaddr = vaddr; e.vline = vline; e.stall = stall; e.gdelay = gdelay;
    return e;
  endfunction

  function automatic exp_t mk_exp(int lat, int cw, logic [31:0] cwd, logic [3:0] cwb, int fill,
                                  int mem_n, logic m0we, logic [31:0] m0a, logic [127:0] m0d,
                                  logic [15:0] m0b, logic m1we, logic [31:0] m1a,
                                  logic [127:0] m1d, logic [15:0] m1b);
    exp_t x;
    x.pop_lat = lat; x.cw = cw; x.cw_data = cwd; x.cw_be = cwb; x.fill = fill;
    x.mem_n = mem_n; x.m0_we = m0we; x.m0_addr = m0a; x.m0_wdata = m0d; x.m0_wbe = m0b;
    x.m1_we = m1we; x.m1_addr = m1a; x.m1_wdata = m1d; x.m1_wbe = m1b;
    return x;
  endfunction

  // What the memory and cache should see for one entry.
  function automatic exp_t model(entry_t e);
    logic [31:0]  line;
    int           off;
    line = e.tag - (e.tag % 16);
    off  = int'((e.tag % 16) / 4);
    if (e.hit) return mk_exp(2, 1, e.data, e.bytes, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef STOREBUFFER_DRAIN_WRITE_ALLOCATE_EN
    if (e.vdirty)
      return mk_exp(-1, 1, e.data, e.bytes, 1, 2, 1, e.vaddr, e.vline, 16'hFFFF,
                    0, line, 0, 0);
    return mk_exp(-1, 1, e.data, e.bytes, 1, 1, 0, line, 0, 0, 0, 0, 0, 0);
`else
    return mk_exp(-1, 0, 0, 0, 0, 1, 1, line, 128'(e.data) << (32 * off),
                  16'(e.bytes) << (4 * off), 0, 0, 0, 0);
`endif
  endfunction

  // Present one entry and play cache and memory until it is popped.
  task automatic run_entry(input entry_t e);
    int     req_cyc    = -1;
    bit     lookup_nxt = 0;
    int     stall_left = e.stall;
    int     gdelay     = e.gdelay;
    bit     rd_wait    = 0;
    int     rd_delay   = 0;
    bit     prev_stall = 0;
    bit     done       = 0;
    logic [176:0] prev_fields = '0;
    o_pop = 0; o_pop_lat = -1; o_cw = 0; o_fill = 0; o_mem_n = 0; o_unstable = 0;
    o_err = 0; o_timeout = 0; o_req = 0; o_req_addr = 0;
    rd_data_used = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clock); #1;
    sb_empty = 0; sb_tag = e.tag; sb_data = e.data; sb_bytes = e.bytes;
    cache_grant = (gdelay == 0);
    cache_victim_dirty = e.vdirty; cache_victim_addr = e.vaddr; cache_victim_line = e.vline;
    cache_hit = 0; mem_rvalid = 0;
    mem_ready = (stall_left == 0) ? 1'($urandom) : 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clock);
      if (sb_pop && sb_empty) o_err++;
      if (mem_valid && !busy) o_err++;
      if (cache_req) begin
        if (req_cyc < 0) req_cyc = cyc;
        o_req++;
        o_req_addr = cache_addr;
      end
      lookup_nxt = cache_req;
      if (cache_we) begin
        o_cw++; o_cw_addr = cache_addr; o_cw_data = cache_wdata; o_cw_be = cache_wbe;
      end
      if (cache_fill) begin o_fill++; o_fill_line = cache_fill_line; end
      if (mem_valid) begin
        if (prev_stall && {mem_we, mem_addr, mem_wdata, mem_wbe} != prev_fields) o_unstable++;
        if (mem_ready) begin
          if (o_mem_n < 2) begin
            o_m_we[o_mem_n] = mem_we; o_m_addr[o_mem_n] = mem_addr;
            o_m_wdata[o_mem_n] = mem_wdata; o_m_wbe[o_mem_n] = mem_wbe;
          end
          o_mem_n++;
          if (!mem_we) begin rd_wait = 1; rd_delay = $urandom_range(0, 3); end
          prev_stall = 0;
        end else begin
          prev_stall  = 1;
          prev_fields = {mem_we, mem_addr, mem_wdata, mem_wbe};
          if (sb_pop) o_err++;
          if (stall_left > 0) stall_left--;
        end
      end else if (prev_stall) begin
        o_unstable++;
        prev_stall = 0;
      end
      if (sb_pop) begin o_pop++; o_pop_lat = cyc - req_cyc; done = 1; end
      @(posedge clock); #1;
      if (done) begin
        sb_empty = 1; cache_grant = 0;
      end else begin
        if (gdelay > 0) gdelay--;
        cache_grant = (gdelay == 0);
      end
      cache_hit = lookup_nxt ? e.hit : 1'($urandom);
      mem_ready = (stall_left > 0) ? 1'b0 : 1'($urandom);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (rd_wait) begin
        mem_rvalid = 0;
        if (rd_delay == 0) begin mem_rvalid = 1; mem_rdata = rd_data_used; rd_wait = 0; end
        else rd_delay--;
      end else begin
        mem_rvalid = 1'($urandom);
      end
    end
    if (!done) o_timeout = 1;
    sb_empty = 1; cache_grant = 0; mem_rvalid = 0; mem_ready = 0;
  endtask

  task automatic check_entry(input string nm, input entry_t e, input exp_t x);
    check({nm, " timeout"}, 128'(o_timeout), 0);
    check({nm, " pop count"}, 128'(o_pop), 1);
    check({nm, " protocol errors"}, 128'(o_err), 0);
    check({nm, " mem fields unstable"}, 128'(o_unstable), 0);
    check({nm, " lookup count"}, 128'(o_req), 1);
    check({nm, " lookup addr"}, o_req_addr, e.tag);
    if (x.pop_lat >= 0) check({nm, " pop latency"}, 128'(o_pop_lat), 128'(x.pop_lat));
    check({nm, " cache write count"}, 128'(o_cw), 128'(x.cw));
    if (x.cw > 0) begin
      check({nm, " cache write addr"}, o_cw_addr, e.tag);
      check({nm, " cache write data"}, o_cw_data, x.cw_data);
      check({nm, " cache write be"}, o_cw_be, x.cw_be);
    end
    check({nm, " fill count"}, 128'(o_fill), 128'(x.fill));
    if (x.fill > 0) check({nm, " fill line"}, o_fill_line, rd_data_used);
    check({nm, " mem request count"}, 128'(o_mem_n), 128'(x.mem_n));
    if (x.mem_n > 0 && o_mem_n > 0) begin
      check({nm, " mem0 we"}, o_m_we[0], x.m0_we);
      check({nm, " mem0 addr"}, o_m_addr[0], x.m0_addr);
      if (x.m0_we) begin
        check({nm, " mem0 wdata"}, o_m_wdata[0], x.m0_wdata);
        check({nm, " mem0 wbe"}, o_m_wbe[0], x.m0_wbe);
      end
    end
    if (x.mem_n > 1 && o_mem_n > 1) begin
      check({nm, " mem1 we"}, o_m_we[1], x.m1_we);
      check({nm, " mem1 addr"}, o_m_addr[1], x.m1_addr);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t   vecs[6];
    entry_t e;
    bit     got;
    bit     bad;

    // Power-on reset with a pending entry: nothing may leak out.
    reset = 1; sb_empty = 0; sb_tag = 32'h100; sb_data = 0; sb_bytes = 4'hF;
    cache_grant = 1; cache_hit = 0; cache_victim_dirty = 0; cache_victim_addr = 0;
    cache_victim_line = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset: cache_req", cache_req, 0);
    check("reset: busy", busy, 0);
    check("reset: mem_valid", mem_valid, 0);
    check("reset: cache_addr", cache_addr, 0);
    @(posedge clock); #1;
    reset = 0; sb_empty = 1; cache_grant = 0;
    @(negedge clock);
    check("idle: busy", busy, 0);
    check("idle: outputs", {cache_req, sb_pop, cache_we, cache_fill, mem_valid}, 0);

    vecs[0].in = mk_in(32'h100, 32'hAABBCCDD, 4'hF, 1, 0, 0, 0, 0, 0);
    vecs[0].ex = mk_exp(2, 1, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1].in = mk_in(32'h3FC, 32'h12345678, 4'h5, 1, 1, 32'h700, 0, 0, 2);
    vecs[1].ex = mk_exp(2, 1, 32'h12345678, 4'h5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2].in = mk_in(32'h208, 32'h11223344, 4'hC, 0, 0, 32'h500, 0, 0, 0);
    vecs[3].in = mk_in(32'h204, 32'hDEADBEEF, 4'h3, 0, 0, 32'h600, 0, 0, 0);
    vecs[4].in = mk_in(32'h204, 32'hCAFEF00D, 4'h3, 0, 1, 32'h300,
                       128'h0123456789ABCDEF_FEDCBA9876543210, 0, 0);
    vecs[5].in = mk_in(32'h20C, 32'h55667788, 4'h8, 0, 0, 32'h400, 0, 5, 0);
`ifdef STOREBUFFER_DRAIN_WRITE_ALLOCATE_EN
    vecs[2].ex = mk_exp(-1, 1, 32'h11223344, 4'hC, 1, 1, 0, 32'h200, 0, 0, 0, 0, 0, 0);
    vecs[3].ex = mk_exp(-1, 1, 32'hDEADBEEF, 4'h3, 1, 1, 0, 32'h200, 0, 0, 0, 0, 0, 0);
    vecs[4].ex = mk_exp(-1, 1, 32'hCAFEF00D, 4'h3, 1, 2, 1, 32'h300,
                        128'h0123456789ABCDEF_FEDCBA9876543210, 16'hFFFF, 0, 32'h200, 0, 0);
    vecs[5].ex = mk_exp(-1, 1, 32'h55667788, 4'h8, 1, 1, 0, 32'h200, 0, 0, 0, 0, 0, 0);
`else
    vecs[2].ex = mk_exp(-1, 0, 0, 0, 0, 1, 1, 32'h200,
                        128'h00000000_11223344_00000000_00000000, 16'h0C00, 0, 0, 0, 0);
    vecs[3].ex = mk_exp(-1, 0, 0, 0, 0, 1, 1, 32'h200,
                        128'h00000000_00000000_DEADBEEF_00000000, 16'h0030, 0, 0, 0, 0);
    vecs[4].ex = mk_exp(-1, 0, 0, 0, 0, 1, 1, 32'h200,
                        128'h00000000_00000000_CAFEF00D_00000000, 16'h0030, 0, 0, 0, 0);
    vecs[5].ex = mk_exp(-1, 0, 0, 0, 0, 1, 1, 32'h200,
                        128'h55667788_00000000_00000000_00000000, 16'h8000, 0, 0, 0, 0);
`endif
    for (int i = 0; i < 6; i++) begin
      run_entry(vecs[i].in);
      check_entry($sformatf("vec%0d", i), vecs[i].in, vecs[i].ex);
    end

    for (int i = 0; i < 40; i++) begin
      e = mk_in(32'($urandom_range(0, 16383)) << 2, $urandom, 4'($urandom),
                1'($urandom), 1'($urandom), 32'($urandom_range(0, 4095)) << 4,
                {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3),
                $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(posedge clock);
      run_entry(e);
      check_entry($sformatf("rand%0d", i), e, model(e));
    end

    // Reset while a miss is outstanding in memory.
    @(posedge clock); #1;
    sb_empty = 0; sb_tag = 32'h208; sb_data = 32'h99887766; sb_bytes = 4'hF;
    cache_grant = 1; cache_hit = 0; cache_victim_dirty = 0; mem_ready = 0; mem_rvalid = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (mem_valid) got = 1;
    end
    check("rst mid: request issued", got, 1);
`ifdef STOREBUFFER_DRAIN_WRITE_ALLOCATE_EN
    @(posedge clock); #1;
    mem_ready = 1;
    @(posedge clock); #1;
    mem_ready = 0;
    @(negedge clock);
    check("rst mid: waiting for fill", {busy, mem_valid}, 2'b10);
`endif
    cache_grant = 0;
    reset = 1;
    #1;
    check("rst mid: outputs during reset", {mem_valid, sb_pop, busy, cache_fill, cache_we}, 0);
    @(posedge clock); #1;
    reset = 0; mem_rvalid = 1; mem_ready = 1; mem_rdata = {4{32'h5A5A5A5A}};
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if ({busy, mem_valid, sb_pop, cache_fill, cache_we} != 0) bad = 1;
    end
    check("rst mid: idle and rvalid ignored", bad, 0);
    mem_rvalid = 0; mem_ready = 0; sb_empty = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/storebuffer_drain.md
STOREBUFFER_DRAIN -- requirements
Module: storebuffer_drain

Interface
REQ-001 The block SHALL have parameter TAG_WIDTH, default `PHYSICAL_ADDR_WIDTH, byte address width of store buffer entries.
REQ-002 The block SHALL have parameter DATA_WIDTH, default `WORD_WIDTH, store buffer entry data width.
REQ-003 The block SHALL have parameter LINE_WIDTH, default 128, cache line and memory beat width.
REQ-004 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clock  in  1  clock; all state on posedge.
- reset  in  1  reset, synchronous, active-high.
- sb_empty  in  1  store buffer holds no entry.
- sb_tag  in  TAG_WIDTH  head entry word-aligned address.
- sb_data  in  DATA_WIDTH  head entry data, byte-lane aligned.
- sb_bytes  in  4  head entry dirty byte mask.
- sb_pop  out  1  one-cycle pulse; retires the head entry.
- cache_grant  in  1  arbiter grants the cache tag port this cycle.
- cache_req  out  1  tag lookup request for cache_addr.
- cache_addr  out  TAG_WIDTH  lookup/write address (latched entry tag).
- cache_hit  in  1  lookup result, valid the cycle after cache_req.
- cache_victim_dirty  in  1  victim line dirty, valid with cache_hit.
- cache_victim_addr  in  TAG_WIDTH  victim line address, valid with cache_hit.
- cache_victim_line  in  LINE_WIDTH  victim line data, valid with cache_hit.
- cache_we  out  1  word write strobe.
- cache_wdata  out  DATA_WIDTH  word write data.
- cache_wbe  out  4  word write byte enables.
- cache_fill  out  1  line install strobe.
- cache_fill_line  out  LINE_WIDTH  line install data.
- mem_valid  out  1  memory request valid; held until mem_ready.
- mem_ready  in  1  memory accepts request this cycle.
- mem_we  out  1  1 = write, 0 = line read.
- mem_addr  out  TAG_WIDTH  request address.
- mem_wdata  out  LINE_WIDTH  write data.
- mem_wbe  out  LINE_WIDTH/8  write byte enables.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  LINE_WIDTH  read data.
- busy  out  1  state is not IDLE.

Function
REQ-005 The block SHALL use states IDLE, LOOKUP, WRITE, EVICT, FILL_REQ, FILL_WAIT, WTHRU.
REQ-006 In IDLE with !sb_empty and cache_grant, the block SHALL assert cache_req, latch sb_tag/sb_data/sb_bytes, and go to LOOKUP; otherwise it SHALL stay in IDLE.
REQ-007 In LOOKUP: hit -> WRITE; miss with dirty victim -> EVICT; miss with clean victim -> FILL_REQ (WTHRU when the macro is absent).
REQ-008 In WRITE, for one cycle, the block SHALL assert cache_we with the latched data, cache_wbe = latched bytes, and sb_pop, then go to IDLE; hit drain latency is 3 cycles, IDLE to pop.
REQ-009 In EVICT, the block SHALL drive mem_we=1, mem_addr=victim address, mem_wdata=victim line, mem_wbe=all ones, and go to FILL_REQ on mem_ready.
REQ-010 In FILL_REQ, the block SHALL drive mem_we=0 with mem_addr = latched tag with its low log2(LINE_WIDTH/8) bits cleared, and go to FILL_WAIT on mem_ready.
REQ-011 In FILL_WAIT on mem_rvalid, the block SHALL pulse cache_fill with cache_fill_line = mem_rdata, then go to WRITE.
REQ-012 mem_valid, mem_addr, mem_we, mem_wdata and mem_wbe SHALL stay stable while mem_valid && !mem_ready.
REQ-013 Only one entry SHALL be in flight; sb_pop SHALL never assert when sb_empty.
REQ-014 mem_rvalid outside FILL_WAIT SHALL be ignored.

Reset
REQ-015 Reset SHALL force IDLE, clear the latched entry, and drive all outputs to 0, including in-flight memory requests; the SB entry is not popped.

Configuration
REQ-016 With STOREBUFFER_DRAIN_WRITE_ALLOCATE_EN defined, misses SHALL allocate (EVICT/FILL path); without it, EVICT/FILL_REQ/FILL_WAIT SHALL be absent, cache_fill SHALL be tied to 0, and a miss SHALL go to WTHRU.
REQ-017 WTHRU SHALL issue mem_we=1 with the word at line offset tag[3:2], matching mem_wbe bits set, and sb_pop plus return to IDLE on mem_ready.

Structure
REQ-018 The drain state enum and LINE_WIDTH constant SHALL live in the shared cache types package; no sub-module is required.

Verification
REQ-019 Hit: tag 0x100, data 0xAABBCCDD, bytes 4'b1111, cache_hit=1 -> cache_we, wbe 1111, sb_pop in cycle 3.
REQ-020 Clean miss (macro on): tag 0x204, bytes 0011 -> mem read 0x200, rdata fill, then cache_we wbe 0011, one pop.
REQ-021 Dirty miss: victim 0x300 dirty -> mem write 0x300 all-ones wbe, then read 0x200, fill, write, pop.
REQ-022 mem_ready held low 5 cycles -> request fields stable, no pop, busy=1.
REQ-023 Reset asserted in FILL_WAIT -> IDLE next cycle, mem_valid=0, no pop; later rvalid ignored.
REQ-024 Macro off, miss at tag 0x208 bytes 1100 -> mem_we=1, mem_wbe=16'h0C00, pop on mem_ready.
